roi_window_gen: RTL
===================

Name: roi_window_gen

Overview:
- Upstream stage of the previous-frame ROI buffer in the KLT tracker.
- Tracks raster coordinates of the incoming pixel stream and latches the tracked point once per frame.
- Emits the delayed pixel together with in_extended_roi (25x25 window), in_roi (21x21 window), an end-of-ROI pulse and a frame-start flag. These feed the ROI buffer and point-update logic.

Parameters:
- NEIGH_SIZE, 10, inner ROI half-width; inner window is 2*NEIGH_SIZE+1 square.
- BORDER_WIDTH, 2, extra margin; extended half-width R_EXT = NEIGH_SIZE+BORDER_WIDTH.
- FRAME_W, 1280, active pixels per line.
- FRAME_H, 720, active lines per frame.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- pixel_in  input  11  incoming pixel, same format as center_pixel.
- de_in  input  1  data enable; one active pixel per cycle while high.
- vsync_in  input  1  frame sync, active high; rising edge = new frame.
- point_x0  input  12  tracked point column for next frame.
- point_y0  input  11  tracked point row for next frame.
- point_valid  input  1  point_x0/point_y0 are valid at the vsync rising edge.
- center_pixel  output  11  pixel_in delayed by 1 cycle.
- in_extended_roi  output  1  center_pixel lies in the extended window.
- in_roi  output  1  center_pixel lies in the inner window.
- roi_end  output  1  one-cycle pulse with the last extended-window pixel.
- center_vsync  output  1  one-cycle pulse, delayed vsync rising edge.
- roi_x0  output  12  latched window centre column in use.
- roi_y0  output  11  latched window centre row in use.

Behaviour:
- Reset (async, rst_n=0): all outputs 0; x_cnt=0, y_cnt=0; latched point = (R_EXT, R_EXT); line_done=0.
- Latency: every output is registered, 1 cycle after the corresponding input sample.
- vsync rising edge:
  - y_cnt<=0, x_cnt<=0.
  - If point_valid=1, latch point_x0/point_y0 (after clamping, see Optional Feature); otherwise keep the previous point.
  - center_vsync=1 on the next cycle.
- de_in=1: x_cnt increments after each pixel.
- de_in falling edge: x_cnt<=0 and y_cnt increments. y_cnt saturates at FRAME_H-1; it never wraps mid-frame.
- Window tests are combinational on (x_cnt, y_cnt) and then registered. Use 13-bit unsigned compares of the form x_cnt+R >= x0 and x_cnt <= x0+R, so nothing underflows near 0.
  - in_extended_roi = de_in & |x-x0|<=R_EXT & |y-y0|<=R_EXT.
  - in_roi = de_in & |x-x0|<=NEIGH_SIZE & |y-y0|<=NEIGH_SIZE.
  - in_roi implies in_extended_roi.
- roi_end = in_extended_roi & x==min(x0+R_EXT, FRAME_W-1) & y==min(y0+R_EXT, FRAME_H-1).
- de_in=0: in_roi and in_extended_roi are 0; center_pixel still follows pixel_in.
- vsync and de high in the same cycle: vsync wins; counters clear and the pixel is treated as (0,0) with the new point.
- Mid-frame reset: counters restart at 0. Pixels until the next vsync use the default point and may be misaligned; this is accepted.
- Changing point_x0/point_y0 outside the vsync edge has no effect.

Optional Feature:
- Macro ROI_POINT_CLAMP_EN.
- Defined:
  - Latched x0 is clamped to [R_EXT, FRAME_W-1-R_EXT] and y0 to [R_EXT, FRAME_H-1-R_EXT].
  - The extended window is always fully inside the frame: exactly 625 in_extended_roi cycles and 441 in_roi cycles per frame (defaults).
- Undefined:
  - The point is latched unclamped and the window is clipped at frame edges.
  - Fewer flagged pixels occur near borders; the roi_end position follows the min() rule above.

Test Plan:
- Reset then point (100,50) with point_valid at vsync, full 1280x720 frame -> in_extended_roi high for x 88..112, y 38..62: 625 cycles. in_roi for x 90..110, y 40..60: 441 cycles. Single roi_end at (112,62).
- Clamp enabled, point (3,5) -> latched roi_x0=12, roi_y0=12; first extended pixel at (0,0); 625 flagged cycles.
- Clamp disabled, point (3,5) -> window x 0..15, y 0..17 = 288 extended cycles; roi_end at (15,17).
- point_valid=0 at the second vsync with new inputs (400,300) -> roi_x0/roi_y0 keep the previous frame's point; same flag counts as the prior frame.
- Pixel value 0x5A3 at de-on cycle -> center_pixel=0x5A3 one cycle later; center_vsync pulses exactly 1 cycle after the vsync rising edge.
- rst_n asserted mid-ROI (line 45) -> all outputs 0 immediately (async); after release, the next vsync restores correct counts.

Source files
------------

// File: rtl/roi_window_gen.sv
// roi_window_gen: raster coordinate tracker and ROI window flag generator for
// the previous-frame ROI buffer of the KLT tracker.
//
// Latches the tracked point once per frame on the vsync rising edge. Outputs
// the pixel delayed by one cycle, together with the extended-window flag, the
// inner-window flag, an end-of-ROI pulse and a frame-start pulse.
//
// Optional feature: define ROI_POINT_CLAMP_EN to clamp the latched point so
// that the extended window always lies fully inside the frame.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   pixel_in[10:0]      incoming pixel
//   de_in               data enable, one pixel per cycle while high
//   vsync_in            frame sync, rising edge starts a frame
//   point_x0/point_y0   tracked point for the next frame
//   point_valid         point is valid at the vsync rising edge
//   center_pixel        pixel_in delayed by one cycle
//   in_extended_roi     pixel lies in the (2*R_EXT+1)^2 window
//   in_roi              pixel lies in the (2*NEIGH_SIZE+1)^2 window
//   roi_end             pulse with the last extended-window pixel
//   center_vsync        pulse one cycle after the vsync rising edge
//   roi_x0/roi_y0       window centre in use
module roi_window_gen #(
    parameter int unsigned NEIGH_SIZE   = 10,
    parameter int unsigned BORDER_WIDTH = 2,
    parameter int unsigned FRAME_W      = 1280,
    parameter int unsigned FRAME_H      = 720
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [10:0] pixel_in,
    input  logic        de_in,
    input  logic        vsync_in,
    input  logic [11:0] point_x0,
    input  logic [10:0] point_y0,
    input  logic        point_valid,
    output logic [10:0] center_pixel,
    output logic        in_extended_roi,
    output logic        in_roi,
    output logic        roi_end,
    output logic        center_vsync,
    output logic [11:0] roi_x0,
    output logic [10:0] roi_y0
);

    localparam int unsigned R_EXT = NEIGH_SIZE + BORDER_WIDTH;
    localparam int unsigned XW    = 12;
    localparam int unsigned YW    = 11;
    localparam int unsigned PW    = 11;
    localparam int unsigned CW    = 13;

    // Unsigned window test written so that nothing underflows near 0
    function automatic logic in_range(input logic [CW-1:0] c,
                                      input logic [CW-1:0] ctr,
                                      input logic [CW-1:0] r);
        return ((c + r) >= ctr) && (c <= (ctr + r));
    endfunction

    logic          vsync_q, de_q;
    logic [XW-1:0] x_cnt_q, x_cnt_d;
    logic [YW-1:0] y_cnt_q, y_cnt_d;
    logic [XW-1:0] x0_q, x0_d;
    logic [YW-1:0] y0_q, y0_d;

    logic [PW-1:0] pix_q;
    logic          ext_q, roi_q, end_q, cvs_q;
    logic [XW-1:0] rx_q;
    logic [YW-1:0] ry_q;

    logic          vs_rise;
    logic [XW-1:0] x_cur, px_sel;
    logic [YW-1:0] y_cur, py_sel;
    logic [CW-1:0] x_lim, y_lim;
    logic          ext_hit, roi_hit, end_hit;

    // Point selection, clamped when the feature is enabled
    always_comb begin
        px_sel = point_x0;
        py_sel = point_y0;
`ifdef ROI_POINT_CLAMP_EN
        if (point_x0 < XW'(R_EXT))
            px_sel = XW'(R_EXT);
        else if (point_x0 > XW'(FRAME_W - 1 - R_EXT))
            px_sel = XW'(FRAME_W - 1 - R_EXT);
        if (point_y0 < YW'(R_EXT))
            py_sel = YW'(R_EXT);
        else if (point_y0 > YW'(FRAME_H - 1 - R_EXT))
            py_sel = YW'(FRAME_H - 1 - R_EXT);
`endif
    end

    // Current coordinates/point (vsync edge takes priority) and window flags
    always_comb begin
        vs_rise = vsync_in & ~vsync_q;
        x_cur   = vs_rise ? '0 : x_cnt_q;
        y_cur   = vs_rise ? '0 : y_cnt_q;
        x0_d    = (vs_rise && point_valid) ? px_sel : x0_q;
        y0_d    = (vs_rise && point_valid) ? py_sel : y0_q;

        ext_hit = de_in
                & in_range(CW'(x_cur), CW'(x0_d), CW'(R_EXT))
                & in_range(CW'(y_cur), CW'(y0_d), CW'(R_EXT));
        roi_hit = de_in
                & in_range(CW'(x_cur), CW'(x0_d), CW'(NEIGH_SIZE))
                & in_range(CW'(y_cur), CW'(y0_d), CW'(NEIGH_SIZE));

        // Last window pixel is clipped to the frame edge when unclamped
        x_lim = CW'(x0_d) + CW'(R_EXT);
        if (x_lim > CW'(FRAME_W - 1))
            x_lim = CW'(FRAME_W - 1);
        y_lim = CW'(y0_d) + CW'(R_EXT);
        if (y_lim > CW'(FRAME_H - 1))
            y_lim = CW'(FRAME_H - 1);
        end_hit = ext_hit & (CW'(x_cur) == x_lim) & (CW'(y_cur) == y_lim);

        // Counter update: pixel advance, line end on de falling edge
        x_cnt_d = x_cur;
        y_cnt_d = y_cur;
        if (de_in) begin
            x_cnt_d = (x_cur == '1) ? x_cur : x_cur + XW'(1);
        end else if (de_q && !vs_rise) begin
            x_cnt_d = '0;
            y_cnt_d = (y_cur >= YW'(FRAME_H - 1)) ? y_cur : y_cur + YW'(1);
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_q <= 1'b0;
            de_q    <= 1'b0;
            x_cnt_q <= '0;
            y_cnt_q <= '0;
            x0_q    <= XW'(R_EXT);
            y0_q    <= YW'(R_EXT);
            pix_q   <= '0;
            ext_q   <= 1'b0;
            roi_q   <= 1'b0;
            end_q   <= 1'b0;
            cvs_q   <= 1'b0;
            rx_q    <= '0;
            ry_q    <= '0;
        end else begin
            vsync_q <= vsync_in;
            de_q    <= de_in;
            x_cnt_q <= x_cnt_d;
            y_cnt_q <= y_cnt_d;
            x0_q    <= x0_d;
            y0_q    <= y0_d;
            pix_q   <= pixel_in;
            ext_q   <= ext_hit;
            roi_q   <= roi_hit;
            end_q   <= end_hit;
            cvs_q   <= vs_rise;
            rx_q    <= x0_d;
            ry_q    <= y0_d;
        end
    end

    assign center_pixel    = pix_q;
    assign in_extended_roi = ext_q;
    assign in_roi          = roi_q;
    assign roi_end         = end_q;
    assign center_vsync    = cvs_q;
    assign roi_x0          = rx_q;
    assign roi_y0          = ry_q;

endmodule
